// File: rtl/sramlike_pkg.sv
// Shared request types and byte-lane helpers for the SRAM-like responder.
package sramlike_pkg;

  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;

  typedef struct packed {
    logic        wr;
    logic [1:0]  size;
    logic [31:0] addr;
    logic [31:0] wdata;
  } req_entry_t;

  // Size 2'b11 behaves as a word access.
  function automatic logic [3:0] byte_en(input logic [1:0] size, input logic [1:0] off);
    case (size)
      SZ_BYTE: byte_en = 4'b0001 << off;
      SZ_HALF: byte_en = 4'b0011 << off;
      SZ_WORD: byte_en = 4'b1111;
      default: byte_en = 4'b1111;
    endcase
  endfunction

  function automatic logic misaligned(input logic [1:0] size, input logic [1:0] off);
    case (size)
      SZ_BYTE: misaligned = 1'b0;
      SZ_HALF: misaligned = off[0];
      SZ_WORD: misaligned = (off != 2'b00);
      default: misaligned = (off != 2'b00);
    endcase
  endfunction

endpackage

// File: rtl/sramlike_req_fifo.sv
// In-order request queue; every entry counts down from LATENCY-1 and the head
// is ready once its count has reached zero.
module sramlike_req_fifo
  import sramlike_pkg::*;
#(
  parameter int unsigned QDEPTH  = 4,
  parameter int unsigned LATENCY = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       push,
  input  req_entry_t push_entry,
  input  logic       pop,
  output logic       full,
  output logic       head_valid,
  output logic       head_ready,
  output req_entry_t head_entry
);

  localparam int unsigned PtrW   = $clog2(QDEPTH);
  localparam int unsigned CountW = PtrW + 1;
  localparam int unsigned CntW   = (LATENCY > 1) ? $clog2(LATENCY) : 1;
  localparam logic [CountW-1:0] DepthCount = CountW'(QDEPTH);
  localparam logic [CntW-1:0]   CntInit    = CntW'(LATENCY - 1);

  logic [PtrW-1:0]   rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
  logic [CountW-1:0] count_q, count_d;
  logic [QDEPTH-1:0] valid_q, valid_d;
  logic [CntW-1:0]   cnt_q   [QDEPTH];
  logic [CntW-1:0]   cnt_d   [QDEPTH];
  req_entry_t        entry_q [QDEPTH];
  req_entry_t        entry_d [QDEPTH];
  logic              do_push, do_pop;

  assign full       = (count_q == DepthCount);
  assign head_valid = valid_q[rd_ptr_q];
  assign head_ready = head_valid && (cnt_q[rd_ptr_q] == '0);
  assign head_entry = entry_q[rd_ptr_q];

  // A slot freed by this cycle's pop is not reusable until the next cycle.
  assign do_push = push & ~full;
  assign do_pop  = pop & head_valid;

  always_comb begin
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    valid_d  = valid_q;
    cnt_d    = cnt_q;
    entry_d  = entry_q;
    for (int i = 0; i < QDEPTH; i++) begin
      if (valid_q[i] && (cnt_q[i] != '0)) begin
        cnt_d[i] = cnt_q[i] - 1'b1;
      end
    end
    if (do_pop) begin
      valid_d[rd_ptr_q] = 1'b0;
      rd_ptr_d          = rd_ptr_q + 1'b1;
    end
    if (do_push) begin
      valid_d[wr_ptr_q] = 1'b1;
      cnt_d[wr_ptr_q]   = CntInit;
      entry_d[wr_ptr_q] = push_entry;
      wr_ptr_d          = wr_ptr_q + 1'b1;
    end
    case ({do_push, do_pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
      valid_q  <= '0;
    end else begin
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
      valid_q  <= valid_d;
    end
  end

  // Payload and countdown are only meaningful under valid_q, so they skip reset.
  always_ff @(posedge clk) begin
    cnt_q   <= cnt_d;
    entry_q <= entry_d;
  end

endmodule

// File: rtl/sramlike_resp_mem.sv
// SRAM-like responder backed by a word-organised memory. Defining
// SRAMLIKE_RESP_STALL_EN adds LFSR-driven stalls on both handshakes.
module sramlike_resp_mem
  import sramlike_pkg::*;
#(
  parameter int unsigned MEM_WORDS = 1024,
  parameter int unsigned LATENCY   = 2,
  parameter int unsigned QDEPTH    = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req,
  input  logic        wr,
  input  logic [1:0]  size,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  output logic        addr_ok,
  output logic        data_ok,
  output logic [31:0] rdata
);

  localparam int unsigned IdxW = $clog2(MEM_WORDS);

  logic            full, head_valid, head_ready;
  logic            accept_gate, done_gate;
  req_entry_t      push_entry, head;
  logic [IdxW-1:0] idx;
  logic [3:0]      be;
  logic            mem_we;
  logic            unused_addr_hi;
  logic [31:0]     mem_q [MEM_WORDS];

`ifdef SRAMLIKE_RESP_STALL_EN
  logic [7:0] lfsr_q, lfsr_d;

  // Fibonacci form of x^8+x^6+x^5+x^4+1.
  always_comb lfsr_d = {lfsr_q[6:0], lfsr_q[7] ^ lfsr_q[5] ^ lfsr_q[4] ^ lfsr_q[3]};

  always_ff @(posedge clk) begin
    if (rst) lfsr_q <= 8'hA5;
    else     lfsr_q <= lfsr_d;
  end

  assign accept_gate = lfsr_q[0];
  assign done_gate   = lfsr_q[1];
`else
  assign accept_gate = 1'b1;
  assign done_gate   = 1'b1;
`endif

  assign addr_ok    = req & ~full & ~rst & accept_gate;
  assign data_ok    = head_valid & head_ready & ~rst & done_gate;
  assign push_entry = '{wr: wr, size: size, addr: addr, wdata: wdata};

  sramlike_req_fifo #(
    .QDEPTH  (QDEPTH),
    .LATENCY (LATENCY)
  ) u_fifo (
    .clk        (clk),
    .rst        (rst),
    .push       (addr_ok),
    .push_entry (push_entry),
    .pop        (data_ok),
    .full       (full),
    .head_valid (head_valid),
    .head_ready (head_ready),
    .head_entry (head)
  );

  // Upper address bits wrap onto the array.
  assign idx            = head.addr[IdxW+1:2];
  assign unused_addr_hi = ^head.addr[31:IdxW+2];
  assign be             = byte_en(head.size, head.addr[1:0]);
  assign mem_we         = data_ok & head.wr & ~misaligned(head.size, head.addr[1:0]);

  always_ff @(posedge clk) begin
    if (mem_we) begin
      for (int b = 0; b < 4; b++) begin
        if (be[b]) mem_q[idx][8*b +: 8] <= head.wdata[8*b +: 8];
      end
    end
  end

  always_comb begin
    rdata = '0;
    if (data_ok && !head.wr) rdata = mem_q[idx];
  end

endmodule

// File: tb/tb_sramlike_resp_mem.sv
// Bench for sramlike_resp_mem: three instances with different latency/depth,
// a cycle-level reference model, a vector table and targeted sequences.
module tb_sramlike_resp_mem;

  localparam int NI = 3;
  localparam int MW = 64;
  localparam int L0 = 2, Q0 = 4;
  localparam int L1 = 4, Q1 = 2;
  localparam int L2 = 1, Q2 = 4;

  logic clk = 1'b0;
  logic rst;
  logic [NI-1:0] req_v, wr_v, aok_w, dok_w;
  logic [1:0]    size_v  [NI];
  logic [31:0]   addr_v  [NI];
  logic [31:0]   wdata_v [NI];
  logic [31:0]   rdata_w [NI];

  always #5 clk = ~clk;

  sramlike_resp_mem #(.MEM_WORDS(MW), .LATENCY(L0), .QDEPTH(Q0)) u0 (
    .clk(clk), .rst(rst), .req(req_v[0]), .wr(wr_v[0]), .size(size_v[0]), .addr(addr_v[0]),
    .wdata(wdata_v[0]), .addr_ok(aok_w[0]), .data_ok(dok_w[0]), .rdata(rdata_w[0]));
  sramlike_resp_mem #(.MEM_WORDS(MW), .LATENCY(L1), .QDEPTH(Q1)) u1 (
    .clk(clk), .rst(rst), .req(req_v[1]), .wr(wr_v[1]), .size(size_v[1]), .addr(addr_v[1]),
    .wdata(wdata_v[1]), .addr_ok(aok_w[1]), .data_ok(dok_w[1]), .rdata(rdata_w[1]));
  sramlike_resp_mem #(.MEM_WORDS(MW), .LATENCY(L2), .QDEPTH(Q2)) u2 (
    .clk(clk), .rst(rst), .req(req_v[2]), .wr(wr_v[2]), .size(size_v[2]), .addr(addr_v[2]),
    .wdata(wdata_v[2]), .addr_ok(aok_w[2]), .data_ok(dok_w[2]), .rdata(rdata_w[2]));

  typedef struct packed {
    logic        wr;
    logic [1:0]  size;
    logic [31:0] addr;
    logic [31:0] wdata;
    int          due;
  } ment_t;

  typedef struct packed {
    logic        wr;
    logic [1:0]  size;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] exp;
  } vec_t;

  ment_t       mq    [NI][$];
  logic [31:0] mem_m [NI][MW];
  int          cyc, n_checks, n_pass;
  bit          obs_aok [NI], obs_dok [NI], e_aok [NI], e_dok [NI];
  logic [31:0] obs_rd  [NI];

  function automatic int lat_of(input int i);
    return (i == 0) ? L0 : (i == 1) ? L1 : L2;
  endfunction

  function automatic int qd_of(input int i);
    return (i == 0) ? Q0 : (i == 1) ? Q1 : Q2;
  endfunction

  function automatic logic [31:0] word_of(input int i, input logic [31:0] a);
    return mem_m[i][(a >> 2) % MW];
  endfunction

  // Writes touch nbytes lanes starting at addr%4, and only when naturally aligned.
  function automatic void model_write(input int i, input ment_t e);
    int nb, w, off;
    nb  = (e.size == 2'd0) ? 1 : (e.size == 2'd1) ? 2 : 4;
    w   = int'((e.addr >> 2) % MW);
    off = int'(e.addr % 4);
    if (off % nb != 0) return;
    for (int k = 0; k < nb; k++) begin
      mem_m[i][w][8*(off+k) +: 8] = e.wdata[8*(off+k) +: 8];
    end
  endfunction

  task automatic chk(input string name, input int inst, input logic [31:0] act,
                     input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s[%0d] cycle %0d: got %h, want %h", name, inst, cyc, act, exp);
  endtask

  // One clock: compare every instance at the falling edge, advance the model at the rising edge.
  task automatic step();
    @(negedge clk);
    for (int i = 0; i < NI; i++) begin
      e_aok[i]   = req_v[i] && (mq[i].size() < qd_of(i));
      e_dok[i]   = (mq[i].size() > 0) && (mq[i][0].due == cyc);
      obs_aok[i] = aok_w[i];
      obs_dok[i] = dok_w[i];
      obs_rd[i]  = rdata_w[i];
      chk("addr_ok", i, 32'(aok_w[i]), 32'(e_aok[i]));
      chk("data_ok", i, 32'(dok_w[i]), 32'(e_dok[i]));
      if (!e_dok[i]) chk("rdata_idle", i, rdata_w[i], 32'h0);
      else if (!mq[i][0].wr) chk("rdata", i, rdata_w[i], word_of(i, mq[i][0].addr));
    end
    @(posedge clk);
    for (int i = 0; i < NI; i++) begin
      int    due;
      ment_t h;
      if (rst) begin
        mq[i].delete();
      end else begin
        due = cyc + lat_of(i);
        if (mq[i].size() > 0 && mq[i][$].due + 1 > due) due = mq[i][$].due + 1;
        if (e_dok[i]) begin
          h = mq[i].pop_front();
          if (h.wr) model_write(i, h);
        end
        if (e_aok[i]) begin
          h.wr = wr_v[i]; h.size = size_v[i]; h.addr = addr_v[i];
          h.wdata = wdata_v[i]; h.due = due;
          mq[i].push_back(h);
        end
      end
    end
    cyc++;
    #1;
  endtask

  task automatic idle(input int n);
    req_v = '0;
    repeat (n) step();
  endtask

  // Single transaction: hold req until accepted, then wait for data_ok (bounded).
  task automatic xact(input int i, input logic w, input logic [1:0] sz, input logic [31:0] a,
                      input logic [31:0] d, output logic [31:0] rd, output int lat);
    int n;
    n = 0;
    req_v[i] = 1'b1; wr_v[i] = w; size_v[i] = sz; addr_v[i] = a; wdata_v[i] = d;
    do begin
      step();
      n++;
    end while (!obs_aok[i] && n < 20);
    req_v[i] = 1'b0;
    lat = 0;
    rd  = '0;
    for (int k = 1; k <= 20; k++) begin
      step();
      if (obs_dok[i]) begin
        lat = k;
        rd  = obs_rd[i];
        break;
      end
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    vec_t        tbl [16];
    int          ptr [NI];
    logic [31:0] rd;
    int          lat, outst, maxout;
    bit          busy, a1, a2, d_any;
    logic [11:0] aokv, dokv;
    logic [4:0]  v5a, v5d;
    logic [31:0] rdv [5];

    tbl[0]  = '{1'b1, 2'b10, 32'h10,  32'hDEADBEEF, 32'h0};
    tbl[1]  = '{1'b0, 2'b10, 32'h10,  32'h0,        32'hDEADBEEF};
    tbl[2]  = '{1'b1, 2'b10, 32'h4,   32'h0,        32'h0};
    tbl[3]  = '{1'b1, 2'b00, 32'h6,   32'h00AB0000, 32'h0};
    tbl[4]  = '{1'b0, 2'b10, 32'h4,   32'h0,        32'h00AB0000};
    tbl[5]  = '{1'b1, 2'b01, 32'h4,   32'h00001234, 32'h0};
    tbl[6]  = '{1'b0, 2'b10, 32'h4,   32'h0,        32'h00AB1234};
    tbl[7]  = '{1'b1, 2'b01, 32'h7,   32'hFFFFFFFF, 32'h0};
    tbl[8]  = '{1'b0, 2'b10, 32'h4,   32'h0,        32'h00AB1234};
    tbl[9]  = '{1'b1, 2'b10, 32'h20,  32'h12345678, 32'h0};
    tbl[10] = '{1'b1, 2'b10, 32'h22,  32'hAAAAAAAA, 32'h0};
    tbl[11] = '{1'b0, 2'b10, 32'h20,  32'h0,        32'h12345678};
    tbl[12] = '{1'b0, 2'b00, 32'h23,  32'h0,        32'h12345678};
    tbl[13] = '{1'b0, 2'b10, 32'h120, 32'h0,        32'h12345678};
    tbl[14] = '{1'b1, 2'b11, 32'h30,  32'h0BADF00D, 32'h0};
    tbl[15] = '{1'b0, 2'b10, 32'h30,  32'h0,        32'h0BADF00D};

    n_checks = 0; n_pass = 0; cyc = 0;
    rst = 1'b1; req_v = '0; wr_v = '0;
    for (int i = 0; i < NI; i++) begin
      size_v[i] = 2'b0; addr_v[i] = '0; wdata_v[i] = '0;
    end
    repeat (3) step();
    rst = 1'b0;
    idle(2);

    // Preload every word of every instance with random data.
    for (int i = 0; i < NI; i++) ptr[i] = 0;
    for (int n = 0; n < 2000; n++) begin
      busy = 1'b0;
      for (int i = 0; i < NI; i++) begin
        if (ptr[i] < MW) begin
          req_v[i] = 1'b1; wr_v[i] = 1'b1; size_v[i] = 2'b10;
          addr_v[i] = 32'(ptr[i] * 4); wdata_v[i] = $urandom; busy = 1'b1;
        end else begin
          req_v[i] = 1'b0;
        end
      end
      if (!busy) break;
      step();
      for (int i = 0; i < NI; i++) if (obs_aok[i]) ptr[i]++;
    end
    idle(10);

    for (int t = 0; t < 16; t++) begin
      xact(0, tbl[t].wr, tbl[t].size, tbl[t].addr, tbl[t].wdata, rd, lat);
      chk("tbl_latency", t, 32'(lat), 32'(L0));
      if (!tbl[t].wr) chk("tbl_rdata", t, rd, tbl[t].exp);
    end

    // Byte write followed immediately by a word read of the same word.
    xact(0, 1'b1, 2'b10, 32'h4, 32'h0, rd, lat);
    req_v[0] = 1'b1; wr_v[0] = 1'b1; size_v[0] = 2'b00; addr_v[0] = 32'h6;
    wdata_v[0] = 32'h00AB0000;
    step(); a1 = obs_aok[0];
    wr_v[0] = 1'b0; size_v[0] = 2'b10; addr_v[0] = 32'h4;
    step(); a2 = obs_aok[0];
    req_v[0] = 1'b0;
    v5d = '0;
    for (int k = 0; k < 5; k++) begin
      step();
      v5d[k] = obs_dok[0];
      if (k == 1) rd = obs_rd[0];
    end
    chk("b2b_accept", 0, 32'({a1, a2}), 32'h3);
    chk("b2b_data_ok", 0, 32'(v5d), 32'h03);
    chk("b2b_rdata", 0, rd, 32'h00AB0000);

    // Queue full on the LATENCY=4, QDEPTH=2 instance.
    req_v[1] = 1'b1; wr_v[1] = 1'b0; size_v[1] = 2'b10; addr_v[1] = 32'h0;
    outst = 0; maxout = 0;
    for (int k = 0; k < 12; k++) begin
      step();
      aokv[k] = obs_aok[1];
      dokv[k] = obs_dok[1];
      outst = outst + int'(obs_aok[1]) - int'(obs_dok[1]);
      if (outst > maxout) maxout = outst;
    end
    idle(12);
    chk("qfull_addr_ok", 1, 32'(aokv), 32'(12'b110001100011));
    chk("qfull_data_ok", 1, 32'(dokv), 32'(12'b011000110000));
    chk("qfull_max_outstanding", 1, 32'(maxout), 32'd2);

    // LATENCY=1: handshakes overlap with completions.
    for (int k = 0; k < 5; k++) begin
      req_v[2] = 1'b1; wr_v[2] = 1'b0; size_v[2] = 2'b10; addr_v[2] = 32'(4 * k);
      step();
      v5a[k] = obs_aok[2]; v5d[k] = obs_dok[2]; rdv[k] = obs_rd[2];
    end
    idle(4);
    chk("ovl_addr_ok", 2, 32'(v5a), 32'h1F);
    chk("ovl_data_ok", 2, 32'(v5d), 32'h1E);
    for (int k = 1; k < 4; k++) chk("ovl_rdata_order", 2, rdv[k], mem_m[2][k-1]);

    // Reset while a write is in flight.
    xact(0, 1'b1, 2'b10, 32'h20, 32'h5555AAAA, rd, lat);
    req_v[0] = 1'b1; wr_v[0] = 1'b1; size_v[0] = 2'b10; addr_v[0] = 32'h20;
    wdata_v[0] = 32'h12345678;
    step();
    chk("rst_seq_accept", 0, 32'(obs_aok[0]), 32'h1);
    req_v[0] = 1'b0; rst = 1'b1;
    step(); d_any = obs_dok[0];
    rst = 1'b0; req_v[0] = 1'b1; wr_v[0] = 1'b0;
    step(); d_any |= obs_dok[0];
    chk("rst_addr_ok_after", 0, 32'(obs_aok[0]), 32'h1);
    req_v[0] = 1'b0;
    step(); d_any |= obs_dok[0];
    step();
    chk("rst_no_data_ok", 0, 32'(d_any), 32'h0);
    chk("rst_read_data_ok", 0, 32'(obs_dok[0]), 32'h1);
    chk("rst_mem_unchanged", 0, obs_rd[0], 32'h5555AAAA);

    // Misaligned word write completes but leaves memory untouched.
    xact(0, 1'b1, 2'b10, 32'h22, 32'hFFFFFFFF, rd, lat);
    chk("mis_latency", 0, 32'(lat), 32'(L0));
    xact(0, 1'b0, 2'b10, 32'h20, 32'h0, rd, lat);
    chk("mis_mem_unchanged", 0, rd, 32'h5555AAAA);

    // Random traffic on all instances against the model.
    for (int n = 0; n < 600; n++) begin
      for (int i = 0; i < NI; i++) begin
        req_v[i]   = ($urandom_range(0, 99) < 65);
        wr_v[i]    = 1'($urandom_range(0, 1));
        size_v[i]  = 2'($urandom_range(0, 3));
        addr_v[i]  = ($urandom_range(0, 1) != 0) ? $urandom : 32'($urandom_range(0, 255));
        wdata_v[i] = $urandom;
      end
      step();
    end
    idle(12);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
